// File: rtl/sequencer_pkg.sv
// Shared types for the SRAM stage sequencer: FSM state encoding (exported on
// state_o) and stage-count-independent constants.
package sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE           = 3'd0,
    S_ENABLE_UART_RX = 3'd1,
    S_UART_RX        = 3'd2,
    S_STAGE          = 3'd3,
    S_GAP            = 3'd4
  } seq_state_t;

  localparam int DEFAULT_UART_TIMEOUT = 50_000_000;

endpackage

// File: rtl/sram_port_mux.sv
// Combinational owner select for the single SRAM controller port: UART during
// load states, the active stage while it runs, VGA fetches otherwise.
module sram_port_mux
  import sequencer_pkg::*;
#(
  parameter int NUM_STAGES = 3,
  parameter int ADDR_W     = 18,
  parameter int DATA_W     = 16,
  localparam int IDX_W     = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  seq_state_t                         state,
  input  logic [IDX_W-1:0]                   active_stage,
  input  logic [ADDR_W-1:0]                  uart_addr,
  input  logic [DATA_W-1:0]                  uart_wdata,
  input  logic                               uart_we_n,
  input  logic [NUM_STAGES-1:0][ADDR_W-1:0]  stage_addr,
  input  logic [NUM_STAGES-1:0][DATA_W-1:0]  stage_wdata,
  input  logic [NUM_STAGES-1:0]              stage_we_n,
  input  logic [ADDR_W-1:0]                  vga_addr,
  output logic [ADDR_W-1:0]                  sram_addr,
  output logic [DATA_W-1:0]                  sram_wdata,
  output logic                               sram_we_n
);

  always_comb begin
    sram_addr  = vga_addr;
    sram_wdata = '0;
    sram_we_n  = 1'b1;
    case (state)
      S_ENABLE_UART_RX, S_UART_RX: begin
        sram_addr  = uart_addr;
        sram_wdata = uart_wdata;
        sram_we_n  = uart_we_n;
      end
      S_STAGE: begin
        sram_addr  = stage_addr[active_stage];
        sram_wdata = stage_wdata[active_stage];
        sram_we_n  = stage_we_n[active_stage];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/sram_stage_sequencer.sv
// UART image load followed by a skippable run of decoder stages sharing one
// SRAM port. Optional per-stage watchdog: define SEQ_WATCHDOG_EN.
module sram_stage_sequencer
  import sequencer_pkg::*;
#(
  parameter int NUM_STAGES      = 3,
  parameter int ADDR_W          = 18,
  parameter int DATA_W          = 16,
  parameter int TIMER_W         = 26,
  parameter int UART_TIMEOUT    = DEFAULT_UART_TIMEOUT,
  parameter int WATCHDOG_CYCLES = 2**24,
  localparam int IDX_W          = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                               CLOCK_50_I,
  input  logic                               resetn,
  input  logic                               uart_rx_line_i,
  input  logic                               start_pb_i,
  input  logic                               run_i,
  input  logic [NUM_STAGES-1:0]              stage_skip_i,
  input  logic [ADDR_W-1:0]                  uart_addr_i,
  input  logic [DATA_W-1:0]                  uart_wdata_i,
  input  logic                               uart_we_n_i,
  output logic                               uart_init_o,
  output logic                               uart_en_o,
  input  logic [NUM_STAGES-1:0][ADDR_W-1:0]  stage_addr_i,
  input  logic [NUM_STAGES-1:0][DATA_W-1:0]  stage_wdata_i,
  input  logic [NUM_STAGES-1:0]              stage_we_n_i,
  input  logic [NUM_STAGES-1:0]              stage_finish_i,
  output logic [NUM_STAGES-1:0]              stage_enable_o,
  input  logic [ADDR_W-1:0]                  vga_addr_i,
  output logic                               vga_enable_o,
  output logic [ADDR_W-1:0]                  sram_addr_o,
  output logic [DATA_W-1:0]                  sram_wdata_o,
  output logic                               sram_we_n_o,
  output logic [IDX_W-1:0]                   active_stage_o,
  output logic [2:0]                         state_o,
  output logic                               done_o,
  output logic                               error_o
);

  localparam logic [NUM_STAGES-1:0] STAGE_ONE = NUM_STAGES'(1);

  seq_state_t            state_q;
  logic [NUM_STAGES-1:0] skip_q;
  logic [TIMER_W-1:0]    timer_q;
  logic                  load_req;
  logic                  wd_expire;
  logic                  first_found, next_found;
  logic [IDX_W-1:0]      first_idx, next_idx;

  assign state_o  = state_q;
  assign load_req = (state_q == S_IDLE) && (!uart_rx_line_i || start_pb_i);

  // Descending scan so the last hit is the lowest qualifying index.
  always_comb begin
    first_found = 1'b0;
    first_idx   = '0;
    next_found  = 1'b0;
    next_idx    = '0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      if (!stage_skip_i[i]) begin
        first_found = 1'b1;
        first_idx   = IDX_W'(i);
      end
      if (!skip_q[i] && (i > int'(active_stage_o))) begin
        next_found = 1'b1;
        next_idx   = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      timer_q <= '0;
    end else if (uart_init_o || !uart_we_n_i) begin
      timer_q <= '0;
    end else if (timer_q != '1) begin
      timer_q <= timer_q + TIMER_W'(1);
    end
  end

  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      state_q        <= S_IDLE;
      vga_enable_o   <= 1'b1;
      stage_enable_o <= '0;
      uart_init_o    <= 1'b0;
      uart_en_o      <= 1'b0;
      done_o         <= 1'b0;
      active_stage_o <= '0;
      skip_q         <= '0;
    end else begin
      uart_init_o <= 1'b0;
      uart_en_o   <= 1'b0;
      done_o      <= 1'b0;
      case (state_q)
        S_IDLE: begin
          vga_enable_o <= 1'b1;
          if (load_req) begin
            uart_init_o  <= 1'b1;
            vga_enable_o <= 1'b0;
            state_q      <= S_ENABLE_UART_RX;
          end else if (run_i) begin
            skip_q <= stage_skip_i;
            if (first_found) begin
              active_stage_o <= first_idx;
              stage_enable_o <= STAGE_ONE << first_idx;
              state_q        <= S_STAGE;
            end else begin
              done_o <= 1'b1;
            end
          end
        end
        S_ENABLE_UART_RX: begin
          uart_en_o <= 1'b1;
          state_q   <= S_UART_RX;
        end
        S_UART_RX: begin
          if (timer_q == TIMER_W'(UART_TIMEOUT - 1)) begin
            uart_init_o  <= 1'b1;
            vga_enable_o <= 1'b1;
            skip_q       <= stage_skip_i;
            if (first_found) begin
              active_stage_o <= first_idx;
              stage_enable_o <= STAGE_ONE << first_idx;
              state_q        <= S_STAGE;
            end else begin
              done_o  <= 1'b1;
              state_q <= S_IDLE;
            end
          end
        end
        S_STAGE: begin
          if (stage_finish_i[active_stage_o]) begin
            stage_enable_o <= '0;
            state_q        <= S_GAP;
          end else if (wd_expire) begin
            stage_enable_o <= '0;
            state_q        <= S_IDLE;
          end
        end
        S_GAP: begin
          if (next_found) begin
            active_stage_o <= next_idx;
            stage_enable_o <= STAGE_ONE << next_idx;
            state_q        <= S_STAGE;
          end else begin
            done_o  <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef SEQ_WATCHDOG_EN
  localparam int WD_W = $clog2(WATCHDOG_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt_q;
  logic            run_req;

  assign run_req   = (state_q == S_IDLE) && !load_req && run_i;
  assign wd_expire = (state_q == S_STAGE) && (wd_cnt_q == WD_W'(WATCHDOG_CYCLES - 1));

  // Counter sits at zero outside S_STAGE, so every stage entry starts fresh.
  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      wd_cnt_q <= '0;
      error_o  <= 1'b0;
    end else begin
      if (state_q != S_STAGE) wd_cnt_q <= '0;
      else if (!wd_expire)    wd_cnt_q <= wd_cnt_q + WD_W'(1);
      if (load_req || run_req) error_o <= 1'b0;
      else if (wd_expire && !stage_finish_i[active_stage_o]) error_o <= 1'b1;
    end
  end
`else
  logic unused_wd;
  assign unused_wd = (WATCHDOG_CYCLES == 0);
  assign wd_expire = 1'b0;
  assign error_o   = 1'b0;
`endif

  sram_port_mux #(
    .NUM_STAGES (NUM_STAGES),
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W)
  ) u_mux (
    .state        (state_q),
    .active_stage (active_stage_o),
    .uart_addr    (uart_addr_i),
    .uart_wdata   (uart_wdata_i),
    .uart_we_n    (uart_we_n_i),
    .stage_addr   (stage_addr_i),
    .stage_wdata  (stage_wdata_i),
    .stage_we_n   (stage_we_n_i),
    .vga_addr     (vga_addr_i),
    .sram_addr    (sram_addr_o),
    .sram_wdata   (sram_wdata_o),
    .sram_we_n    (sram_we_n_o)
  );

endmodule

// File: tb/tb_sram_stage_sequencer.sv
// Directed-plus-random bench for sram_stage_sequencer; the expected stage walk
// is the ascending list of unskipped indices. Watchdog steps need SEQ_WATCHDOG_EN.
module tb_sram_stage_sequencer;
  import sequencer_pkg::*;

  localparam int NS = 3;
  localparam int AW = 18;
  localparam int DW = 16;
  localparam int TO = 100;
  localparam int WD = 50;

  logic                  clk = 1'b0;
  logic                  resetn;
  logic                  uart_rx_line_i, start_pb_i, run_i;
  logic [NS-1:0]         stage_skip_i;
  logic [AW-1:0]         uart_addr_i;
  logic [DW-1:0]         uart_wdata_i;
  logic                  uart_we_n_i;
  logic                  uart_init_o, uart_en_o;
  logic [NS-1:0][AW-1:0] stage_addr_i;
  logic [NS-1:0][DW-1:0] stage_wdata_i;
  logic [NS-1:0]         stage_we_n_i, stage_finish_i, stage_enable_o;
  logic [AW-1:0]         vga_addr_i, sram_addr_o;
  logic                  vga_enable_o;
  logic [DW-1:0]         sram_wdata_o;
  logic                  sram_we_n_o;
  logic [1:0]            active_stage_o;
  logic [2:0]            state_o;
  logic                  done_o, error_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sram_stage_sequencer #(
    .NUM_STAGES (NS), .ADDR_W (AW), .DATA_W (DW), .TIMER_W (26),
    .UART_TIMEOUT (TO), .WATCHDOG_CYCLES (WD)
  ) dut (
    .CLOCK_50_I     (clk),
    .resetn         (resetn),
    .uart_rx_line_i (uart_rx_line_i),
    .start_pb_i     (start_pb_i),
    .run_i          (run_i),
    .stage_skip_i   (stage_skip_i),
    .uart_addr_i    (uart_addr_i),
    .uart_wdata_i   (uart_wdata_i),
    .uart_we_n_i    (uart_we_n_i),
    .uart_init_o    (uart_init_o),
    .uart_en_o      (uart_en_o),
    .stage_addr_i   (stage_addr_i),
    .stage_wdata_i  (stage_wdata_i),
    .stage_we_n_i   (stage_we_n_i),
    .stage_finish_i (stage_finish_i),
    .stage_enable_o (stage_enable_o),
    .vga_addr_i     (vga_addr_i),
    .vga_enable_o   (vga_enable_o),
    .sram_addr_o    (sram_addr_o),
    .sram_wdata_o   (sram_wdata_o),
    .sram_we_n_o    (sram_we_n_o),
    .active_stage_o (active_stage_o),
    .state_o        (state_o),
    .done_o         (done_o),
    .error_o        (error_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic randomize_clients();
    for (int i = 0; i < NS; i++) begin
      stage_addr_i[i]  = AW'($urandom);
      stage_wdata_i[i] = DW'($urandom);
      stage_we_n_i[i]  = 1'($urandom);
    end
    vga_addr_i = AW'($urandom);
  endtask

  // Called at the negedge where the first unskipped stage (or done) is visible.
  task automatic walk(input logic [NS-1:0] mask);
    int list[$];
    for (int i = 0; i < NS; i++) if (!mask[i]) list.push_back(i);
    if (list.size() == 0) begin
      chk("alldone_done", done_o, 1);
      chk("alldone_en", stage_enable_o, 0);
      chk("alldone_state", state_o, S_IDLE);
      @(negedge clk);
      chk("alldone_pulse", done_o, 0);
      return;
    end
    foreach (list[j]) begin
      int idx = list[j];
      int dwell = $urandom_range(1, 5);
      logic [NS-1:0] oh = NS'(1) << idx;
      for (int d = 0; d < dwell; d++) begin
        randomize_clients();
        #1;
        chk("stage_en", stage_enable_o, oh);
        chk("stage_state", state_o, S_STAGE);
        chk("stage_active", active_stage_o, idx);
        chk("stage_addr", sram_addr_o, stage_addr_i[idx]);
        chk("stage_wdata", sram_wdata_o, stage_wdata_i[idx]);
        chk("stage_we_n", sram_we_n_o, stage_we_n_i[idx]);
        chk("stage_done", done_o, 0);
        chk("stage_err", error_o, 0);
        stage_finish_i = (d == dwell - 1) ? (NS'($urandom) | oh) : (NS'($urandom) & ~oh);
        @(negedge clk);
      end
      stage_finish_i = '0;
      randomize_clients();
      #1;
      chk("gap_en", stage_enable_o, 0);
      chk("gap_state", state_o, S_GAP);
      chk("gap_addr", sram_addr_o, vga_addr_i);
      chk("gap_wdata", sram_wdata_o, 0);
      chk("gap_we_n", sram_we_n_o, 1);
      @(negedge clk);
    end
    chk("end_done", done_o, 1);
    chk("end_state", state_o, S_IDLE);
    chk("end_en", stage_enable_o, 0);
    @(negedge clk);
    chk("end_pulse", done_o, 0);
  endtask

  task automatic pulse_run(input logic [NS-1:0] mask);
    @(negedge clk);
    run_i = 1'b1;
    stage_skip_i = mask;
    @(negedge clk);
    run_i = 1'b0;
    stage_skip_i = NS'($urandom);
  endtask

  // Starts at the first negedge in S_UART_RX; counts cycles until it exits.
  task automatic wait_rx(input string tag);
    int n = 0;
    while (state_o == S_UART_RX && n < 300) begin
      n++;
      @(negedge clk);
    end
    chk(tag, n, TO);
    chk("rx_exit_init", uart_init_o, 1);
    chk("rx_exit_vga", vga_enable_o, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [NS-1:0] m;
    resetn = 1'b0; uart_rx_line_i = 1'b1; start_pb_i = 1'b0; run_i = 1'b0;
    stage_skip_i = '0; uart_addr_i = '0; uart_wdata_i = '0; uart_we_n_i = 1'b1;
    stage_finish_i = '0;
    randomize_clients();
    repeat (3) @(negedge clk);
    #1;
    chk("rst_state", state_o, S_IDLE);
    chk("rst_vga_en", vga_enable_o, 1);
    chk("rst_en", stage_enable_o, 0);
    chk("rst_we_n", sram_we_n_o, 1);
    chk("rst_addr", sram_addr_o, vga_addr_i);
    chk("rst_pulses", {uart_init_o, uart_en_o, done_o, error_o}, 0);
    chk("rst_active", active_stage_o, 0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // UART load with four writes, then full walk
    stage_skip_i = '0;
    uart_rx_line_i = 1'b0;
    @(negedge clk);
    uart_rx_line_i = 1'b1;
    #1;
    chk("ld_state", state_o, S_ENABLE_UART_RX);
    chk("ld_init", uart_init_o, 1);
    chk("ld_vga", vga_enable_o, 0);
    chk("ld_addr", sram_addr_o, uart_addr_i);
    @(negedge clk);
    chk("ld_rx_state", state_o, S_UART_RX);
    chk("ld_uart_en", uart_en_o, 1);
    chk("ld_init_pulse", uart_init_o, 0);
    for (int w = 0; w < 4; w++) begin
      if (w > 0) repeat ($urandom_range(0, 3)) @(negedge clk);
      uart_addr_i = AW'($urandom); uart_wdata_i = DW'($urandom); uart_we_n_i = 1'b0;
      #1;
      chk("ld_w_addr", sram_addr_o, uart_addr_i);
      chk("ld_w_data", sram_wdata_o, uart_wdata_i);
      chk("ld_w_we_n", sram_we_n_o, 0);
      @(negedge clk);
      uart_we_n_i = 1'b1;
    end
    stage_skip_i = 3'b000;
    wait_rx("ld_timeout");
    walk(3'b000);

    pulse_run(3'b010);
    walk(3'b010);
    pulse_run(3'b111);
    walk(3'b111);
    for (int r = 0; r < 5; r++) begin
      m = NS'($urandom);
      pulse_run(m);
      walk(m);
    end

    // run_i and start_pb_i together: load wins
    @(negedge clk);
    m = NS'($urandom);
    run_i = 1'b1; start_pb_i = 1'b1; stage_skip_i = m;
    @(negedge clk);
    run_i = 1'b0; start_pb_i = 1'b0;
    #1;
    chk("sim_state", state_o, S_ENABLE_UART_RX);
    chk("sim_init", uart_init_o, 1);
    chk("sim_en", stage_enable_o, 0);
    @(negedge clk);
    chk("sim_rx_state", state_o, S_UART_RX);
    wait_rx("sim_timeout");
    walk(m);

    // asynchronous reset in the middle of a stage
    pulse_run(3'b000);
    #1;
    chk("ar_pre_en", stage_enable_o, 3'b001);
    @(negedge clk);
    #2;
    resetn = 1'b0;
    #1;
    chk("ar_en", stage_enable_o, 0);
    chk("ar_state", state_o, S_IDLE);
    chk("ar_addr", sram_addr_o, vga_addr_i);
    chk("ar_vga", vga_enable_o, 1);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("ar_idle", state_o, S_IDLE);

`ifdef SEQ_WATCHDOG_EN
    begin
      int n = 0;
      pulse_run(3'b000);
      while (stage_enable_o != 0 && n < 200) begin
        chk("wd_done_low", done_o, 0);
        n++;
        @(negedge clk);
      end
      chk("wd_cycles", n, WD);
      chk("wd_err", error_o, 1);
      chk("wd_state", state_o, S_IDLE);
      chk("wd_done", done_o, 0);
      @(negedge clk);
      chk("wd_sticky", error_o, 1);
      pulse_run(3'b111);
      chk("wd_clear", error_o, 0);
      walk(3'b111);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
